// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order fetch queue over a latency-tolerant imem port,
// wrong-path response dropping after redirect, and the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_if,
  input  logic                stall_id,
  input  logic                flush_id,
  input  logic                ex_pc_src,
  input  logic [31:0]         ex_pc_target,
  fetch_unit_if.master        imem,
  output logic [31:0]         id_instr,
  output logic [31:0]         id_pc,
  output logic [31:0]         id_pc_plus4,
  output logic                id_valid,
  output logic                fetch_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Headroom for wrong-path responses piling up across back-to-back redirects.
  localparam int DW = AW + 4;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  logic [31:0]      fetch_pc;
  logic [31:0]      q_pc    [DEPTH];
  logic [31:0]      q_instr [DEPTH];
  logic [DEPTH-1:0] q_filled;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW-1:0]    fill_ptr;
  logic [CW-1:0]    alloc;
  logic [CW-1:0]    pend;
  logic [DW-1:0]    drop_cnt;

  logic req_fire;
  logic resp_drop;
  logic resp_fill;
  logic head_ready;
  logic pop;

  assign imem.imem_req_valid = !rst && !stall_if && !ex_pc_src && (alloc < FULL);
  assign imem.imem_req_addr  = fetch_pc;

  assign req_fire   = imem.imem_req_valid && imem.imem_req_ready;
  assign resp_drop  = imem.imem_resp_valid && (drop_cnt != '0);
  assign resp_fill  = imem.imem_resp_valid && (drop_cnt == '0);
  assign head_ready = (alloc != '0) && q_filled[head];
  assign pop        = head_ready && !flush_id && !stall_id && !ex_pc_src;

  assign fetch_busy  = !q_filled[head] || (alloc == '0);
  assign id_pc_plus4 = id_pc + 32'd4;

  // pend counts allocated entries still waiting for their word; a redirect
  // turns all of them into responses that must be dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      alloc    <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      q_filled <= '0;
    end else if (ex_pc_src) begin
      fetch_pc <= ex_pc_target;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      alloc    <= '0;
      pend     <= '0;
      q_filled <= '0;
      drop_cnt <= drop_cnt + DW'(pend) - DW'(imem.imem_resp_valid);
    end else begin
      if (req_fire) begin
        q_pc[tail] <= fetch_pc;
        tail       <= tail + AW'(1);
        fetch_pc   <= fetch_pc + 32'd4;
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - DW'(1);
      end
      if (resp_fill) begin
        q_instr[fill_ptr]  <= imem.imem_resp_data;
        q_filled[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + AW'(1);
      end
      if (pop) begin
        q_filled[head] <= 1'b0;
        head           <= head + AW'(1);
      end
      alloc <= alloc + CW'(req_fire) - CW'(pop);
      pend  <= pend + CW'(req_fire) - CW'(resp_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
      id_pc    <= 32'h0;
    end else if (flush_id) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
    end else if (stall_id) begin
      id_valid <= id_valid;
    end else if (pop) begin
      id_valid <= 1'b1;
      id_instr <= q_instr[head];
      id_pc    <= q_pc[head];
    end else begin
      id_valid <= 1'b0;
      id_instr <= NOP;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random stalls/redirects,
// compared against a transaction-level model of the fetch queue and instruction memory.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, flush_id, ex_pc_src;
  logic [31:0] ex_pc_target;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        id_valid, fetch_busy;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .flush_id     (flush_id),
    .ex_pc_src    (ex_pc_src),
    .ex_pc_target (ex_pc_target),
    .imem         (bus),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc_plus4  (id_pc_plus4),
    .id_valid     (id_valid),
    .fetch_busy   (fetch_busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // stimulus controls for the next cycle
  logic        s_if, s_id, fl, rd, rdy;
  logic [31:0] tgt;
  int          lat;

  // reference model: fetch address, queue of correct-path PCs, memory pipeline
  logic [31:0] exp_fetch;
  logic [31:0] mq_pc [$];
  bit          mq_f  [$];
  logic [31:0] mp_addr [$];
  int          mp_due  [$];
  int          mp_ep   [$];
  int          epoch, last_due, cyc;
  logic        m_valid;
  logic [31:0] m_pc, m_instr;

  int first_valid;
  int wrap_seen;
  int redirect_pc_seen;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    if (a == 32'h4) return 32'h0020_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic cycle();
    logic        rv_exp, hs, resp_v, pop;
    logic [31:0] resp_a;
    int          resp_ep, due;
    stall_if     = s_if;
    stall_id     = s_id;
    flush_id     = fl;
    ex_pc_src    = rd;
    ex_pc_target = tgt;
    bus.imem_req_ready = rdy;
    resp_v = (mp_due.size() > 0) && (mp_due[0] == cyc);
    bus.imem_resp_valid = resp_v;
    bus.imem_resp_data  = resp_v ? word(mp_addr[0]) : 32'hDEAD_BEEF;
    #1;
    rv_exp = !s_if && !rd && (mq_pc.size() < DEPTH);
    chk("req_valid", 32'(bus.imem_req_valid), 32'(rv_exp));
    if (rv_exp) chk("req_addr", bus.imem_req_addr, exp_fetch);
    chk("fetch_busy", 32'(fetch_busy), 32'((mq_pc.size() == 0) || !mq_f[0]));
    hs  = rv_exp && rdy;
    pop = !fl && !s_id && !rd && (mq_pc.size() > 0) && mq_f[0];
    @(posedge clk);
    #1;
    resp_a  = 32'h0;
    resp_ep = -1;
    if (resp_v) begin
      resp_a  = mp_addr.pop_front();
      resp_ep = mp_ep.pop_front();
      void'(mp_due.pop_front());
    end
    if (fl) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (s_id) begin
      m_valid = m_valid;
    end else if (pop) begin
      m_valid = 1'b1;
      m_pc    = mq_pc.pop_front();
      void'(mq_f.pop_front());
      m_instr = word(m_pc);
    end else begin
      m_valid = 1'b0;
      m_instr = NOP;
    end
    if (rd) begin
      mq_pc.delete();
      mq_f.delete();
      epoch++;
      exp_fetch = tgt;
    end else begin
      if (resp_v && resp_ep == epoch) begin
        for (int i = 0; i < mq_f.size(); i++) begin
          if (!mq_f[i]) begin
            mq_f[i] = 1'b1;
            break;
          end
        end
      end
      if (hs) begin
        mq_pc.push_back(exp_fetch);
        mq_f.push_back(1'b0);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        mp_addr.push_back(exp_fetch);
        mp_due.push_back(due);
        mp_ep.push_back(epoch);
        last_due  = due;
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    cyc++;
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("id_pc", id_pc, m_pc);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc_plus4", id_pc_plus4, m_pc + 32'd4);
    if (id_valid && first_valid < 0) first_valid = cyc;
    if (id_valid && id_pc == 32'hFFFF_FFFC && id_pc_plus4 == 32'h0) wrap_seen = 1;
    if (id_valid && id_pc == 32'h100) redirect_pc_seen = 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic quiet();
    s_if = 0; s_id = 0; fl = 0; rd = 0; rdy = 1; tgt = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    stall_if = 0; stall_id = 0; flush_id = 0; ex_pc_src = 0; ex_pc_target = 0;
    bus.imem_req_ready = 1; bus.imem_resp_valid = 0; bus.imem_resp_data = 0;
    exp_fetch = 32'h0; epoch = 0; last_due = -1; cyc = 0; lat = 1;
    m_valid = 0; m_pc = 32'h0; m_instr = NOP;
    first_valid = -1; wrap_seen = 0; redirect_pc_seen = 0;
    quiet();
    repeat (2) @(posedge clk);
    #1;
    chk("req_valid_in_rst", 32'(bus.imem_req_valid), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'h4);
    chk("rst_fetch_busy", 32'(fetch_busy), 32'h1);

    // startup with 1-cycle memory
    run(12);
    chk("first_valid_cycle", 32'(first_valid), 32'd3);

    // stall_if for 3 cycles mid-stream
    s_if = 1; run(3);
    s_if = 0; run(6);

    // stall_id for 5 cycles with 3-cycle memory
    lat = 3; run(6);
    s_id = 1; run(5);
    s_id = 0; run(8);

    // redirect to 0x100 with requests in flight
    rd = 1; fl = 1; tgt = 32'h100; run(1);
    quiet(); run(10);
    chk("redirect_target_seen", 32'(redirect_pc_seen), 32'h1);

    // flush and stall_id together
    lat = 1; run(4);
    fl = 1; s_id = 1; run(1);
    quiet(); run(4);

    // PC wrap at 2^32
    rd = 1; fl = 1; tgt = 32'hFFFF_FFF8; run(1);
    quiet(); run(8);
    chk("wrap_seen", 32'(wrap_seen), 32'h1);

    // randomized stalls, redirects, ready gaps and latencies
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) lat = int'($urandom_range(1, 4));
      s_if = ($urandom_range(0, 99) < 15);
      s_id = ($urandom_range(0, 99) < 15);
      rdy  = ($urandom_range(0, 99) < 75);
      rd   = ($urandom_range(0, 99) < 5);
      fl   = rd || ($urandom_range(0, 99) < 4);
      tgt  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'h0000_FFFC);
      cycle();
    end
    quiet();
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed %0d checks, required completion", n_total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 5-stage pipeline. It consumes the stall/flush controls (`stall_if`, `stall_id`, `flush_id`) and the EX-stage redirect (`ex_pc_src`, `ex_pc_target`). It drives a valid/ready request port and an in-order response port to instruction memory, and delivers the IF/ID pipeline register (`id_instr`, `id_pc`, `id_pc_plus4`, `id_valid`) to decode. A small in-order fetch queue absorbs multi-cycle memory latency. Wrong-path responses are discarded after a redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, fetch queue entries (power of 2, ≥2); bounds outstanding requests
- `clk` in 1, sole clock, rising edge
- `rst` in 1, one clock; reset is synchronous and active-high
- `stall_if` in 1, hold fetch PC, issue no new requests
- `stall_id` in 1, hold IF/ID register
- `flush_id` in 1, squash IF/ID register
- `ex_pc_src` in 1, redirect taken in EX
- `ex_pc_target` in 32, redirect target
- `imem_req_valid` out 1, request valid
- `imem_req_ready` in 1, memory accepts request
- `imem_req_addr` out 32, request address
- `imem_resp_valid` in 1, in-order response (no backpressure)
- `imem_resp_data` in 32, instruction word
- `id_instr` out 32, IF/ID instruction
- `id_pc` out 32, IF/ID PC
- `id_pc_plus4` out 32, `id_pc + 4` (mod 2^32)
- `id_valid` out 1, IF/ID holds a real instruction
- `fetch_busy` out 1, queue head not filled (decode would take a bubble)

## Operation
- State:
  - `fetch_pc`.
  - Queue of DEPTH entries {pc, instr, filled} with head/tail pointers and count `alloc`.
  - `drop_cnt`, the number of wrong-path responses still owed by memory.
  - IF/ID register.
- Request issue:
  - `imem_req_valid = !stall_if & !ex_pc_src & (alloc < DEPTH)`.
  - `imem_req_addr = fetch_pc`.
  - On handshake: allocate the tail entry with pc = `fetch_pc`, filled = 0; then `fetch_pc += 4`, wrapping at 2^32.
- Response:
  - If `drop_cnt > 0`: discard the response and decrement `drop_cnt`.
  - Otherwise: write `imem_resp_data` into the oldest unfilled entry and set filled.
  - A response with zero outstanding requests is illegal and need not be handled.
- IF/ID update, in priority order:
  1. `flush_id`: `id_valid←0`, `id_instr←32'h0000_0013` (NOP). The head is not popped.
  2. `stall_id`: hold all IF/ID fields.
  3. Head filled: load its pc/instr, set `id_valid←1`, pop the head.
  4. Otherwise: `id_valid←0`, `id_instr←NOP`, `id_pc` held.
- Redirect (`ex_pc_src`):
  - Has priority over `stall_if`.
  - `fetch_pc←ex_pc_target`.
  - Every queue entry is discarded and `alloc←0`.
  - `drop_cnt←drop_cnt + (unfilled entries) − (1 if a response is discarded or filled this cycle)`.
  - The IF/ID pop is suppressed in a redirect cycle; `flush_id` accompanies it.
- Simultaneous allocate and pop in one cycle: `alloc` is unchanged.
- `fetch_busy = !head.filled | (alloc == 0)`.
- Reset:
  - `fetch_pc=RESET_PC`, queue empty, `drop_cnt=0`.
  - `id_valid=0`, `id_instr=32'h0000_0013`, `id_pc=0`, `id_pc_plus4=4`.
  - `imem_req_valid=0` while `rst` is high.
  - A reset mid-flight abandons in-flight responses; memory is reset together with this block.

## Timing
- `imem_req_valid` and `imem_req_addr` are combinational from registered state and the current stall/redirect inputs. They do not depend on `imem_req_ready`.
- Minimum latency: request accepted in cycle N, response in N+1, head filled visible in N+2, `id_valid=1` with that instruction in N+3.
- With 1-cycle memory and no stalls, sustained throughput is 1 instruction/cycle.
- After a redirect in cycle R:
  - First request to `ex_pc_target` is issued in R+1.
  - Earliest `id_valid` for the target is R+4 with 1-cycle memory.
- `stall_if` does not block responses; in-flight words still fill the queue.

## Test plan
- Reset, `imem_req_ready=1`, 1-cycle memory returning `0x00100093` then `0x00200113` → requests to 0x0, 0x4, …; `id_pc=0x0`, `id_instr=0x00100093`, `id_valid=1` in cycle 3; one instruction per cycle after that.
- `stall_if=1` for 3 cycles mid-stream → `imem_req_valid=0` and `fetch_pc` held; IF/ID keeps draining filled entries; no instruction lost or duplicated after release.
- `stall_id=1` for 5 cycles with 3-cycle memory, DEPTH=4 → at most 4 requests outstanding; `id_*` held; order is preserved on release.
- `ex_pc_src=1`, `ex_pc_target=0x100` with 2 requests in flight → the next 2 responses are dropped; the first `id_valid` after that has `id_pc=0x100`; wrong-path PCs never reach IF/ID.
- `flush_id` and `stall_id` asserted together → `id_valid=0`, `id_instr=0x13`; the head entry remains queued and is delivered next.
- `fetch_pc=0xFFFF_FFFC` → the next request address is 0x0 and `id_pc_plus4=0x0` when `id_pc=0xFFFF_FFFC`.
